// File: rtl/glitc_trig_pkg.sv
// Shared types for the correlator peak trigger: FSM states, default correlation width, peak record.
package glitc_trig_pkg;

  localparam int NCBITS_DEF = 13;

  typedef enum logic [1:0] {IDLE, GATHER, REPORT, HOLD} trig_state_t;

  typedef struct packed {
    logic [NCBITS_DEF-1:0] value;
    logic [1:0]            index;
    logic [7:0]            offset;
  } peak_rec_t;

endpackage

// File: rtl/corr_max4.sv
// Registered max/argmax of four unsigned correlation sums, 1-cycle latency, no backpressure.
module corr_max4
  import glitc_trig_pkg::*;
#(
  parameter int NCBITS = NCBITS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCBITS-1:0] i_corr0,
  input  logic [NCBITS-1:0] i_corr1,
  input  logic [NCBITS-1:0] i_corr2,
  input  logic [NCBITS-1:0] i_corr3,
  input  logic              i_vld,
  output logic [NCBITS-1:0] o_max,
  output logic [1:0]        o_idx,
  output logic              o_vld
);

  logic [NCBITS-1:0] w_max01, w_max23, w_max;
  logic [1:0]        w_idx01, w_idx23, w_idx;
  logic [NCBITS-1:0] r_max;
  logic [1:0]        r_idx;
  logic              r_vld;

  // Strict compares keep the lower channel on ties at every level of the tree.
  assign w_max01 = (i_corr1 > i_corr0) ? i_corr1 : i_corr0;
  assign w_idx01 = (i_corr1 > i_corr0) ? 2'd1 : 2'd0;
  assign w_max23 = (i_corr3 > i_corr2) ? i_corr3 : i_corr2;
  assign w_idx23 = (i_corr3 > i_corr2) ? 2'd3 : 2'd2;
  assign w_max   = (w_max23 > w_max01) ? w_max23 : w_max01;
  assign w_idx   = (w_max23 > w_max01) ? w_idx23 : w_idx01;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max <= '0;
      r_idx <= 2'd0;
      r_vld <= 1'b0;
    end else begin
      r_max <= w_max;
      r_idx <= w_idx;
      r_vld <= i_vld;
    end
  end

  assign o_max = r_max;
  assign o_idx = r_idx;
  assign o_vld = r_vld;

endmodule

// File: rtl/corr_peak_trigger.sv
// Arms on max(CORR) > threshold, gathers the window peak, holds one record until trig_ready, then holds off.
// Define CORR_TRIG_STATS_EN to build the saturating accepted-trigger counter; otherwise trig_count is 0.
module corr_peak_trigger
  import glitc_trig_pkg::*;
#(
  parameter int NCBITS  = NCBITS_DEF,
  parameter int WINDOW  = 8,
  parameter int HOLDOFF = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCBITS-1:0] CORR0,
  input  logic [NCBITS-1:0] CORR1,
  input  logic [NCBITS-1:0] CORR2,
  input  logic [NCBITS-1:0] CORR3,
  input  logic              corr_valid,
  input  logic [NCBITS-1:0] threshold,
  output logic              trig_valid,
  input  logic              trig_ready,
  output logic [NCBITS-1:0] trig_value,
  output logic [1:0]        trig_index,
  output logic [7:0]        trig_offset,
  output logic              busy,
  output logic [15:0]       trig_count
);

  localparam logic [7:0]  WIN8   = 8'(WINDOW);
  localparam logic [15:0] HOLD16 = 16'(HOLDOFF);

  logic [NCBITS-1:0] w_s1_max;
  logic [1:0]        w_s1_idx;
  logic              w_s1_vld;

  trig_state_t r_state;
  peak_rec_t   r_peak;
  logic [7:0]  r_win;
  logic [15:0] r_hold;
  logic        r_trig_valid;
  logic        r_busy;

  corr_max4 #(.NCBITS(NCBITS)) u_max4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_corr0 (CORR0),
    .i_corr1 (CORR1),
    .i_corr2 (CORR2),
    .i_corr3 (CORR3),
    .i_vld   (corr_valid),
    .o_max   (w_s1_max),
    .o_idx   (w_s1_idx),
    .o_vld   (w_s1_vld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_peak       <= '0;
      r_win        <= 8'd0;
      r_hold       <= 16'd0;
      r_trig_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_s1_vld && (w_s1_max > threshold)) begin
            r_peak  <= '{value: w_s1_max, index: w_s1_idx, offset: 8'd0};
            r_win   <= 8'd1;
            r_state <= GATHER;
            r_busy  <= 1'b1;
          end
        end
        GATHER: begin
          if (w_s1_vld) begin
            r_win <= r_win + 8'd1;
            // Equal values never replace: the earliest sample of a tie keeps the record.
            if (w_s1_max > r_peak.value)
              r_peak <= '{value: w_s1_max, index: w_s1_idx, offset: r_win};
            if (r_win + 8'd1 == WIN8) begin
              r_state      <= REPORT;
              r_trig_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          if (trig_ready) begin
            r_trig_valid <= 1'b0;
            if (HOLDOFF == 0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= HOLD;
              r_hold  <= HOLD16;
            end
          end
        end
        HOLD: begin
          if (r_hold <= 16'd1) begin
            r_hold  <= 16'd0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold <= r_hold - 16'd1;
          end
        end
      endcase
    end
  end

`ifdef CORR_TRIG_STATS_EN
  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_count <= 16'd0;
    else if (r_trig_valid && trig_ready && (r_count != 16'hFFFF))
      r_count <= r_count + 16'd1;
  end

  assign trig_count = r_count;
`else
  assign trig_count = 16'd0;
`endif

  assign trig_valid  = r_trig_valid;
  assign trig_value  = r_peak.value;
  assign trig_index  = r_peak.index;
  assign trig_offset = r_peak.offset;
  assign busy        = r_busy;

endmodule
